change_dispenser: RTL and testbench

Sequences the coin-return hardware after a transaction. On a start pulse from the transaction FSM, it pays out a change amount of 0–31 ₫ using greedy selection: 10 ₫, then 5 ₫, then 1 ₫. It pays one coin at a time over a req/ack handshake to the ejector motor driver. It also tracks how many coins are in each of the three tubes, including deposits from the coin acceptor, and reports any amount it cannot pay.

---
 rtl/change_dispenser.sv | 156 +++++++++++++++
 tb/tb_change_dispenser.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy 10/5/1 coin payout over a req/ack ejector handshake,
// with per-tube inventory, deposit overflow detection and a sticky ejector-timeout fault.
module change_dispenser #(
    parameter int CNT_W       = 4,
    parameter int TUBE_MAX    = 15,
    parameter int INIT_COUNT  = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       change_amount,
    input  logic [1:0]       coin_deposit,
    input  logic             fault_clr,
    input  logic             eject_ack,
    output logic             eject_req,
    output logic [1:0]       eject_coin,
    output logic             busy,
    output logic             done,
    output logic             short_change,
    output logic [4:0]       owed,
    output logic             overflow,
    output logic             fault,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt5,
    output logic [CNT_W-1:0] cnt10
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GMAX = GW'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMAX = CNT_W'(TUBE_MAX);
    localparam logic [CNT_W-1:0] CINIT = CNT_W'(INIT_COUNT);

    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE} state_t;

    state_t state, state_n;
    logic [4:0] rem, rem_n, owed_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic [1:0] coin_n, pick;
    logic req_n, done_n, short_n, fault_n, ovf_n, take;
    logic inc1, inc5, inc10, dec1, dec5, dec10;

    // A coincident deposit and ejection on one tube cancel out, so a full tube cannot overflow then.
    function automatic logic [CNT_W-1:0] upd(input logic [CNT_W-1:0] c, input logic inc, input logic dec);
        return (inc && dec) ? c : dec ? c - 1'b1 : (inc && c < CMAX) ? c + 1'b1 : c;
    endfunction

    function automatic logic [4:0] val(input logic [1:0] c);
        return (c == 2'b11) ? 5'd10 : (c == 2'b10) ? 5'd5 : 5'd1;
    endfunction

    assign take  = (state == EJECT) && eject_ack;
    assign dec1  = take && eject_coin == 2'b01;
    assign dec5  = take && eject_coin == 2'b10;
    assign dec10 = take && eject_coin == 2'b11;
    assign inc1  = coin_deposit == 2'b01;
    assign inc5  = coin_deposit == 2'b10;
    assign inc10 = coin_deposit == 2'b11;
    assign ovf_n = (inc1 && !dec1 && cnt1 == CMAX) || (inc5 && !dec5 && cnt5 == CMAX) ||
                   (inc10 && !dec10 && cnt10 == CMAX);
    assign pick  = (rem >= 5'd10 && cnt10 != '0) ? 2'b11 :
                   (rem >= 5'd5 && cnt5 != '0)   ? 2'b10 :
                   (rem != 5'd0 && cnt1 != '0)   ? 2'b01 : 2'b00;

    always_comb begin
        state_n = state;
        rem_n   = rem;
        tmr_n   = tmr;
        gcnt_n  = gcnt;
        req_n   = eject_req;
        coin_n  = eject_coin;
        done_n  = 1'b0;
        short_n = short_change;
        owed_n  = owed;
        fault_n = fault_clr ? 1'b0 : fault;
        case (state)
            IDLE: if (start) begin
                rem_n   = change_amount;
                short_n = 1'b0;
                owed_n  = 5'd0;
                state_n = SELECT;
            end
            SELECT: begin
                tmr_n = '0;
                if (pick != 2'b00) begin
                    coin_n  = pick;
                    req_n   = 1'b1;
                    state_n = EJECT;
                end else begin
                    short_n = rem != 5'd0;
                    owed_n  = rem;
                    done_n  = 1'b1;
                    state_n = DONE;
                end
            end
            EJECT: if (eject_ack) begin
                rem_n   = rem - val(eject_coin);
                req_n   = 1'b0;
                gcnt_n  = '0;
                state_n = GAP;
            end else if (tmr == TMAX) begin
                req_n   = 1'b0;
                fault_n = 1'b1;
                short_n = 1'b1;
                owed_n  = rem;
                done_n  = 1'b1;
                state_n = DONE;
            end else begin
                tmr_n = tmr + 1'b1;
            end
            GAP: if (gcnt == GMAX) state_n = SELECT;
                 else gcnt_n = gcnt + 1'b1;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            rem          <= '0;
            tmr          <= '0;
            gcnt         <= '0;
            eject_req    <= 1'b0;
            eject_coin   <= 2'b00;
            busy         <= 1'b0;
            done         <= 1'b0;
            short_change <= 1'b0;
            owed         <= '0;
            overflow     <= 1'b0;
            fault        <= 1'b0;
            cnt1         <= CINIT;
            cnt5         <= CINIT;
            cnt10        <= CINIT;
        end else begin
            state        <= state_n;
            rem          <= rem_n;
            tmr          <= tmr_n;
            gcnt         <= gcnt_n;
            eject_req    <= req_n;
            eject_coin   <= coin_n;
            busy         <= state_n != IDLE;
            done         <= done_n;
            short_change <= short_n;
            owed         <= owed_n;
            overflow     <= ovf_n;
            fault        <= fault_n;
            cnt1         <= upd(cnt1, inc1, dec1);
            cnt5         <= upd(cnt5, inc5, dec5);
            cnt10        <= upd(cnt10, inc10, dec10);
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed and randomized payouts checked against a
// transaction-level greedy model of the tubes and the remaining amount.
module tb_change_dispenser;
    localparam int GAP = 4;
    localparam int TO  = 255;

    logic clk = 1'b0;
    logic reset, start, fault_clr, eject_ack;
    logic [4:0] change_amount;
    logic [1:0] coin_deposit;
    logic eject_req, busy, done, short_change, overflow, fault;
    logic [1:0] eject_coin;
    logic [4:0] owed;
    logic [3:0] cnt1, cnt5, cnt10;

    int nvec = 0, nerr = 0, tcnt = 0;
    int m1, m5, m10;
    bit mfault;

    change_dispenser dut (
        .clk(clk), .reset(reset), .start(start), .change_amount(change_amount),
        .coin_deposit(coin_deposit), .fault_clr(fault_clr), .eject_ack(eject_ack),
        .eject_req(eject_req), .eject_coin(eject_coin), .busy(busy), .done(done),
        .short_change(short_change), .owed(owed), .overflow(overflow), .fault(fault),
        .cnt1(cnt1), .cnt5(cnt5), .cnt10(cnt10)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tcnt++;
    endtask

    // Largest coin that fits the remainder and is in stock; 0 if none.
    function automatic int pick(input int r);
        return (r >= 10 && m10 > 0) ? 10 : (r >= 5 && m5 > 0) ? 5 : (r >= 1 && m1 > 0) ? 1 : 0;
    endfunction

    function automatic logic [1:0] code(input int v);
        return (v == 10) ? 2'b11 : (v == 5) ? 2'b10 : 2'b01;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_cnt1"}, cnt1, m1);
        check({tag, "_cnt5"}, cnt5, m5);
        check({tag, "_cnt10"}, cnt10, m10);
    endtask

    task automatic deposit(input int v);
        bit full;
        full = (v == 1) ? m1 >= 15 : (v == 5) ? m5 >= 15 : m10 >= 15;
        coin_deposit = code(v);
        tick();
        coin_deposit = 2'b00;
        if (!full) begin
            if (v == 1) m1++;
            else if (v == 5) m5++;
            else m10++;
        end
        check("dep_ovf", overflow, full);
        check_counts("dep");
    endtask

    task automatic clear_fault();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        mfault = 1'b0;
        check("fault_clr", fault, 0);
    endtask

    task automatic payout(input int amt, input int dly, input bit to_mode, input bit dep_ack, input bit extra);
        int r, v, t0, last, egap, n;
        bit fin;
        r = amt;
        fin = 1'b0;
        change_amount = 5'(amt);
        start = 1'b1;
        tick();
        start = 1'b0;
        change_amount = 5'($urandom);
        t0 = tcnt;
        last = t0;
        egap = 1;
        check("sel_busy", busy, 1);
        check("sel_req", eject_req, 0);
        tick();
        while (!fin) begin
            if (tcnt - t0 > 3000) begin
                check("bound_done", done, 1);
                fin = 1'b1;
            end else if (done) begin
                check("done_lat", tcnt - last, egap);
                check("short", short_change, r != 0);
                check("owed", owed, r);
                check("done_req", eject_req, 0);
                check("done_busy", busy, 1);
                check("fault", fault, mfault);
                check_counts("done");
                fin = 1'b1;
            end else if (eject_req) begin
                v = pick(r);
                check("req_lat", tcnt - last, egap);
                check("coin", eject_coin, code(v));
                if (to_mode) begin
                    n = 0;
                    while (eject_req && n < 1000) begin
                        n++;
                        tick();
                    end
                    check("to_len", n, TO);
                    mfault = 1'b1;
                    to_mode = 1'b0;
                    last = tcnt;
                    egap = 0;
                end else begin
                    repeat (dly) begin
                        tick();
                        check("hold", {eject_req, eject_coin}, {1'b1, code(v)});
                    end
                    eject_ack = 1'b1;
                    if (dep_ack) coin_deposit = code(v);
                    tick();
                    eject_ack = 1'b0;
                    coin_deposit = 2'b00;
                    check("req_drop", eject_req, 0);
                    if (dep_ack) check("ack_dep_ovf", overflow, 0);
                    else if (v == 10) m10--;
                    else if (v == 5) m5--;
                    else m1--;
                    dep_ack = 1'b0;
                    r -= v;
                    last = tcnt;
                    egap = GAP + 1;
                    if (extra) begin
                        start = 1'b1;
                        change_amount = 5'd7;
                        tick();
                        start = 1'b0;
                        extra = 1'b0;
                    end
                end
            end else begin
                tick();
            end
        end
        tick();
        check("post_done", done, 0);
        check("post_busy", busy, 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        fault_clr = 1'b0;
        eject_ack = 1'b0;
        change_amount = '0;
        coin_deposit = '0;
        m1 = 8; m5 = 8; m10 = 8;
        mfault = 1'b0;
        repeat (3) tick();
        check("rst_req", eject_req, 0);
        check("rst_coin", eject_coin, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_short", short_change, 0);
        check("rst_owed", owed, 0);
        check("rst_ovf", overflow, 0);
        check("rst_fault", fault, 0);
        check_counts("rst");
        reset = 1'b1;
        tick();

        payout(18, 2, 0, 0, 0);
        check("p18_cnt10", cnt10, 7);
        check("p18_cnt5", cnt5, 7);
        check("p18_cnt1", cnt1, 5);

        payout(0, 0, 0, 0, 0);

        payout(5, 0, 1, 0, 0);
        check("to_fault", fault, 1);
        check("to_cnt5", cnt5, 7);
        clear_fault();

        payout(1, 1, 0, 1, 0);
        check("ackdep_cnt1", cnt1, 5);

        while (m1 < 15) deposit(1);
        deposit(1);
        check("full_cnt1", cnt1, 15);

        payout(1, 0, 0, 0, 1);
        repeat (3) begin
            tick();
            check("no_requeue", busy, 0);
        end

        while (m10 > 0) payout(10, 0, 0, 0, 0);
        while (m5 > 0) payout(5, 0, 0, 0, 0);
        while (m1 > 0) payout(1, 0, 0, 0, 0);
        repeat (3) deposit(5);
        payout(25, 1, 0, 0, 0);
        check("p25_owed", owed, 10);
        check("p25_short", short_change, 1);

        payout(18, 0, 0, 0, 0);
        change_amount = 5'd18;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        eject_ack = 1'b1;
        tick();
        eject_ack = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        check("arst_req", eject_req, 0);
        check("arst_busy", busy, 0);
        m1 = 8; m5 = 8; m10 = 8;
        mfault = 1'b0;
        check_counts("arst");
        @(negedge clk) reset = 1'b1;
        tick();

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 4))
                0: deposit($urandom_range(0, 2) == 0 ? 1 : ($urandom_range(0, 1) ? 5 : 10));
                1, 2: payout($urandom_range(0, 31), $urandom_range(0, 5), 0, $urandom_range(0, 3) == 0, 0);
                3: payout(31, $urandom_range(0, 2), 0, 0, 0);
                default: clear_fault();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
